// File: rtl/barrel_8bit_norm_seq_pkg.sv
// barrel_8bit_norm_seq_pkg: state encoding and default sizes for the sequential normalizer
package barrel_8bit_norm_seq_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 3;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/barrel_8bit_norm_seq.sv
// barrel_8bit_norm_seq: shifts a word one bit per cycle toward the chosen end until its lead bit is set
module barrel_8bit_norm_seq
    import barrel_8bit_norm_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In,
    input  logic             Lr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Out,
    output logic [CNT_W-1:0] n,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);
    state_t state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d, out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d;
    logic lr_q, lr_d, zero_q, zero_d, valid_q, valid_d, lead;
    always_comb begin
        lead    = lr_q ? work_q[WIDTH-1] : work_q[0];
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        lr_d    = lr_q;
        out_d   = out_q;
        n_d     = n_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (in_valid) begin
                work_d  = In;
                lr_d    = Lr;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: if (work_q == '0) begin
                out_d   = '0;
                n_d     = '0;
                zero_d  = 1'b1;
                valid_d = 1'b1;
                state_d = DONE;
            end else if (lead) begin
                out_d   = work_q;
                n_d     = cnt_q;
                zero_d  = 1'b0;
                valid_d = 1'b1;
                state_d = DONE;
            end else begin
                work_d = lr_q ? work_q << 1 : work_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            DONE: if (out_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            lr_q    <= 1'b0;
            out_q   <= '0;
            n_q     <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            lr_q    <= lr_d;
            out_q   <= out_d;
            n_q     <= n_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end
    assign in_ready  = (state_q == IDLE);
    assign Out       = out_q;
    assign n         = n_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;
endmodule

// File: doc/barrel_8bit_norm_seq.md
Name: barrel_8bit_norm_seq

Overview:
- Sequential normalizer: the inverse of the barrel shift. Takes a data word and shifts it one bit per cycle toward the chosen end until the leading bit is set.
- Returns the normalized word and the shift count n, so re-applying a barrel shift by n in the opposite direction recovers the input.
- Sits beside the existing combinational barrel shifter as its decoding counterpart; used for leading/trailing-zero normalization ahead of that shifter.

Parameters:
- WIDTH, 8, data width in bits.
- CNT_W, 3, width of the shift-count output; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- In  input  WIDTH  word to normalize; sampled on accept.
- Lr  input  1  direction, sampled on accept. 1 = normalize toward MSB (count leading zeros). 0 = normalize toward LSB (count trailing zeros).
- in_valid  input  1  In/Lr valid.
- in_ready  output  1  block can accept; high only in IDLE.
- Out  output  WIDTH  normalized word.
- n  output  CNT_W  number of bit positions shifted.
- zero  output  1  input word was all zeros.
- out_valid  output  1  Out/n/zero valid.
- out_ready  input  1  consumer takes the result.

Behaviour:
- Reset:
  - Sync, active-high: one clk edge with rst=1 forces IDLE.
  - Out=0, n=0, zero=0, out_valid=0, in_ready=1 from the cycle after reset.
  - rst overrides every other input, including mid-SHIFT and in DONE. In-flight work is discarded and no result is produced.
- States:
  - IDLE: in_ready=1. On in_valid=1, load the working register with In, latch Lr, clear the counter, go to SHIFT.
  - SHIFT: evaluate the lead bit, which is work[WIDTH-1] when Lr=1 and work[0] when Lr=0.
    - If work==0: zero=1, Out=0, n=0, go to DONE.
    - Else if lead bit==1: Out=work, n=count, zero=0, go to DONE.
    - Else: shift work by 1 toward the lead end (zero fill), count+=1, stay in SHIFT.
  - DONE: out_valid=1. Out/n/zero held stable while out_ready=0. On out_ready=1, go to IDLE and drop out_valid the next cycle.
- Latency: out_valid rises n+1 cycles after the accepting edge. The zero case takes 1 cycle.
- Throughput: one result per n+3 cycles minimum. There is no accept in the same cycle as the DONE handshake.
- Boundaries:
  - count never exceeds WIDTH-1. For a nonzero word the lead bit is guaranteed set after at most WIDTH-1 shifts, so n never wraps.
  - in_valid is ignored outside IDLE; In/Lr changes during SHIFT/DONE have no effect.
  - out_ready outside DONE has no effect.
- Outputs Out/n/zero/out_valid are registered; in_ready is decoded from state.
- Invariant for nonzero input:
  - Lr=1: (Out >> n) == In.
  - Lr=0: (Out << n) == In, truncated to WIDTH.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2. 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH/CNT_W.
- No sub-module: the shift step is a single-bit shift inlined in the FSM datapath. The FSM and datapath live in one module.

Test Plan:
- In=8'h80, Lr=1 → n=0, Out=8'h80, zero=0, out_valid 1 cycle after accept.
- In=8'h01, Lr=1 → n=7, Out=8'h80, out_valid 8 cycles after accept; Out>>n==8'h01.
- In=8'h2C, Lr=0 → n=2, Out=8'h0B, out_valid 3 cycles after accept.
- In=8'h00 (either Lr) → zero=1, Out=8'h00, n=0, out_valid 1 cycle after accept.
- Backpressure: after a result, hold out_ready=0 for 5 cycles while pulsing in_valid with In=8'hFF.
  - Outputs stay stable, in_ready=0, and the new word is not accepted.
  - out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-op: accept In=8'h01, Lr=1; assert rst on cycle 3.
  - Next cycle: IDLE, out_valid=0, Out=0, n=0, in_ready=1.
  - No result ever emitted for that word.
